// File: rtl/dispatch_arbiter.sv
// Round-robin issue arbiter from per-warp dispatchers into a one-entry registered operand-collector stage (1-cycle latency).
// Holds when the collector stalls and refills on the drain edge; completions are routed back combinationally.
module dispatch_arbiter #(
  parameter int  NumWarps        = 8,
  parameter int  NumTags         = 8,
  parameter int  PcWidth         = 32,
  parameter int  WarpWidth       = 32,
  parameter int  RegIdxWidth     = 6,
  parameter int  OperandsPerInst = 2,
  parameter type inst_t          = logic [31:0],
  localparam int WidWidth        = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int TagWidth        = (NumTags > 1) ? $clog2(NumTags) : 1
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic [NumWarps-1:0]                                    disp_valid_i,
  output logic [NumWarps-1:0]                                    disp_ready_o,
  input  logic [NumWarps-1:0][TagWidth-1:0]                      disp_tag_i,
  input  logic [NumWarps-1:0][PcWidth-1:0]                       disp_pc_i,
  input  logic [NumWarps-1:0][WarpWidth-1:0]                     disp_act_mask_i,
  input  inst_t [NumWarps-1:0]                                   disp_inst_i,
  input  logic [NumWarps-1:0][RegIdxWidth-1:0]                   disp_dst_i,
  input  logic [NumWarps-1:0][OperandsPerInst-1:0]               disp_operands_required_i,
  input  logic [NumWarps-1:0][OperandsPerInst-1:0][RegIdxWidth-1:0] disp_operands_i,
  input  logic                                                   opc_ready_i,
  output logic                                                   opc_valid_o,
  output logic [WidWidth-1:0]                                    opc_warp_id_o,
  output logic [TagWidth-1:0]                                    opc_tag_o,
  output logic [PcWidth-1:0]                                     opc_pc_o,
  output logic [WarpWidth-1:0]                                   opc_act_mask_o,
  output inst_t                                                  opc_inst_o,
  output logic [RegIdxWidth-1:0]                                 opc_dst_o,
  output logic [OperandsPerInst-1:0]                             opc_operands_required_o,
  output logic [OperandsPerInst-1:0][RegIdxWidth-1:0]            opc_operands_o,
  input  logic                                                   eu_valid_i,
  input  logic [WidWidth-1:0]                                    eu_warp_id_i,
  input  logic [TagWidth-1:0]                                    eu_tag_i,
  output logic [NumWarps-1:0]                                    disp_eu_valid_o,
  output logic [TagWidth-1:0]                                    disp_eu_tag_o
);

  typedef struct packed {
    logic [TagWidth-1:0]                          tag;
    logic [PcWidth-1:0]                           pc;
    logic [WarpWidth-1:0]                         act_mask;
    inst_t                                        inst;
    logic [RegIdxWidth-1:0]                       dst;
    logic [OperandsPerInst-1:0]                   opreq;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0]  operands;
  } payload_t;

  payload_t            opc_q, opc_d;
  logic                opc_valid_q, opc_valid_d;
  logic [WidWidth-1:0] wid_q, wid_d;
  logic [WidWidth-1:0] ptr_q, ptr_d;

  logic                accept, handshake;
  logic                hi_found, lo_found;
  logic [WidWidth-1:0] hi_idx, lo_idx, gnt_idx;

  assign accept = !opc_valid_q || opc_ready_i;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      if (disp_valid_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = WidWidth'(i);
        if (WidWidth'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = WidWidth'(i);
        end
      end
    end
  end

  assign gnt_idx   = hi_found ? hi_idx : lo_idx;
  assign handshake = accept && lo_found;

  always_comb begin
    disp_ready_o = '0;
    for (int i = 0; i < NumWarps; i++) begin
      disp_ready_o[i] = handshake && (gnt_idx == WidWidth'(i));
    end
  end

  always_comb begin
    opc_valid_d = opc_valid_q;
    opc_d       = opc_q;
    wid_d       = wid_q;
    ptr_d       = ptr_q;
    if (handshake) begin
      opc_valid_d    = 1'b1;
      wid_d          = gnt_idx;
      opc_d.tag      = disp_tag_i[gnt_idx];
      opc_d.pc       = disp_pc_i[gnt_idx];
      opc_d.act_mask = disp_act_mask_i[gnt_idx];
      opc_d.inst     = disp_inst_i[gnt_idx];
      opc_d.dst      = disp_dst_i[gnt_idx];
      opc_d.opreq    = disp_operands_required_i[gnt_idx];
      opc_d.operands = disp_operands_i[gnt_idx];
      // Wrap at NumWarps, not at the pointer's binary range.
      ptr_d = (gnt_idx == WidWidth'(NumWarps - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (opc_ready_i) begin
      opc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opc_valid_q <= 1'b0;
      opc_q       <= '0;
      wid_q       <= '0;
      ptr_q       <= '0;
    end else begin
      opc_valid_q <= opc_valid_d;
      opc_q       <= opc_d;
      wid_q       <= wid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign opc_valid_o             = opc_valid_q;
  assign opc_warp_id_o           = wid_q;
  assign opc_tag_o               = opc_q.tag;
  assign opc_pc_o                = opc_q.pc;
  assign opc_act_mask_o          = opc_q.act_mask;
  assign opc_inst_o              = opc_q.inst;
  assign opc_dst_o               = opc_q.dst;
  assign opc_operands_required_o = opc_q.opreq;
  assign opc_operands_o          = opc_q.operands;

  // Out-of-range completion ids match no dispatcher.
  always_comb begin
    disp_eu_valid_o = '0;
    for (int w = 0; w < NumWarps; w++) begin
      disp_eu_valid_o[w] = eu_valid_i && (eu_warp_id_i == WidWidth'(w));
    end
  end
  assign disp_eu_tag_o = eu_tag_i;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(disp_ready_o));
  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (opc_valid_q && !opc_ready_i) |=> (opc_valid_q && $stable(opc_q) && $stable(wid_q)));
  a_eu_wid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    eu_valid_i |-> (int'(eu_warp_id_i) < NumWarps));

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Directed-vector bench for dispatch_arbiter with the default 8-warp configuration.
module tb_dispatch_arbiter;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [7:0]           disp_valid_i;
  logic [7:0]           disp_ready_o;
  logic [7:0][2:0]      disp_tag_i;
  logic [7:0][31:0]     disp_pc_i;
  logic [7:0][31:0]     disp_act_mask_i;
  logic [7:0][31:0]     disp_inst_i;
  logic [7:0][5:0]      disp_dst_i;
  logic [7:0][1:0]      disp_operands_required_i;
  logic [7:0][1:0][5:0] disp_operands_i;
  logic                 opc_ready_i;
  logic                 opc_valid_o;
  logic [2:0]           opc_warp_id_o;
  logic [2:0]           opc_tag_o;
  logic [31:0]          opc_pc_o;
  logic [31:0]          opc_act_mask_o;
  logic [31:0]          opc_inst_o;
  logic [5:0]           opc_dst_o;
  logic [1:0]           opc_operands_required_o;
  logic [1:0][5:0]      opc_operands_o;
  logic                 eu_valid_i;
  logic [2:0]           eu_warp_id_i;
  logic [2:0]           eu_tag_i;
  logic [7:0]           disp_eu_valid_o;
  logic [2:0]           disp_eu_tag_o;

  int n_vec = 0;
  int n_err = 0;

  dispatch_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_tag_i(disp_tag_i), .disp_pc_i(disp_pc_i), .disp_act_mask_i(disp_act_mask_i),
    .disp_inst_i(disp_inst_i), .disp_dst_i(disp_dst_i),
    .disp_operands_required_i(disp_operands_required_i), .disp_operands_i(disp_operands_i),
    .opc_ready_i(opc_ready_i), .opc_valid_o(opc_valid_o), .opc_warp_id_o(opc_warp_id_o),
    .opc_tag_o(opc_tag_o), .opc_pc_o(opc_pc_o), .opc_act_mask_o(opc_act_mask_o),
    .opc_inst_o(opc_inst_o), .opc_dst_o(opc_dst_o),
    .opc_operands_required_o(opc_operands_required_o), .opc_operands_o(opc_operands_o),
    .eu_valid_i(eu_valid_i), .eu_warp_id_i(eu_warp_id_i), .eu_tag_i(eu_tag_i),
    .disp_eu_valid_o(disp_eu_valid_o), .disp_eu_tag_o(disp_eu_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_opc(input string tag, input logic [2:0] wid, input logic [2:0] t);
    chk({tag, ".valid"}, 64'(opc_valid_o), 64'd1);
    chk({tag, ".wid"}, 64'(opc_warp_id_o), 64'(wid));
    chk({tag, ".tag"}, 64'(opc_tag_o), 64'(t));
  endtask

  initial begin
    rst_ni       = 1'b0;
    disp_valid_i = '0;
    opc_ready_i  = 1'b0;
    eu_valid_i   = 1'b0;
    eu_warp_id_i = '0;
    eu_tag_i     = '0;
    for (int w = 0; w < 8; w++) begin
      disp_tag_i[w]               = 3'(w);
      disp_pc_i[w]                = 32'h1000 + 32'(w) * 32'h10;
      disp_act_mask_i[w]          = 32'hFFFF_0000 | 32'(w);
      disp_inst_i[w]              = 32'hA500_0000 + 32'(w);
      disp_dst_i[w]               = 6'(w + 8);
      disp_operands_required_i[w] = 2'(w);
      disp_operands_i[w][0]       = 6'(w + 16);
      disp_operands_i[w][1]       = 6'(w + 32);
    end
    disp_tag_i[3] = 3'd5;
    disp_pc_i[3]  = 32'h40;

    #1;
    chk("rst.valid", 64'(opc_valid_o), 64'd0);
    chk("rst.wid", 64'(opc_warp_id_o), 64'd0);
    chk("rst.tag", 64'(opc_tag_o), 64'd0);
    chk("rst.pc", 64'(opc_pc_o), 64'd0);
    chk("rst.inst", 64'(opc_inst_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Single warp 3 request
    disp_valid_i = 8'h08;
    opc_ready_i  = 1'b1;
    #1 chk("single.ready", 64'(disp_ready_o), 64'h08);
    tick();
    chk_opc("single", 3'd3, 3'd5);
    chk("single.pc", 64'(opc_pc_o), 64'h40);
    chk("single.mask", 64'(opc_act_mask_o), 64'hFFFF_0003);
    chk("single.inst", 64'(opc_inst_o), 64'hA500_0003);
    chk("single.dst", 64'(opc_dst_o), 64'd11);
    chk("single.opreq", 64'(opc_operands_required_o), 64'd3);
    chk("single.ops", 64'(opc_operands_o), 64'({6'd35, 6'd19}));
    // ptr now 4: warps 0 and 4 requesting, 4 wins
    disp_valid_i = 8'h11;
    #1 chk("ptr4.ready", 64'(disp_ready_o), 64'h10);
    tick();
    chk_opc("ptr4", 3'd4, 3'd4);
    disp_valid_i = 8'h00;
    #1 chk("idle.ready", 64'(disp_ready_o), 64'h00);
    tick();
    chk("drain.valid", 64'(opc_valid_o), 64'd0);
    chk("drain.keep_pc", 64'(opc_pc_o), 64'h1040);

    disp_tag_i[3] = 3'd3;
    disp_pc_i[3]  = 32'h1030;
    rst_ni = 1'b0;
    #1 chk("rst2.valid", 64'(opc_valid_o), 64'd0);
    rst_ni = 1'b1;

    // Fairness: all valid from reset
    disp_valid_i = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1 chk($sformatf("fair%0d.ready", k), 64'(disp_ready_o), 64'(8'h01 << (k % 8)));
      tick();
      chk_opc($sformatf("fair%0d", k), 3'(k % 8), 3'(k % 8));
    end

    // Wrap: steer ptr to 6 via warp 5, then warps 1 and 7
    disp_valid_i = 8'h20;
    tick();
    chk_opc("pre_wrap", 3'd5, 3'd5);
    disp_valid_i = 8'h82;
    #1 chk("wrap7.ready", 64'(disp_ready_o), 64'h80);
    tick();
    chk_opc("wrap7", 3'd7, 3'd7);
    #1 chk("wrap1.ready", 64'(disp_ready_o), 64'h02);
    tick();
    chk_opc("wrap1", 3'd1, 3'd1);
    disp_valid_i = 8'h03;
    #1 chk("ptr2.ready", 64'(disp_ready_o), 64'h01);
    tick();

    // Backpressure: load warp 1 (ptr -> 2), then stall with warps 2 and 5 pending
    disp_valid_i = 8'h02;
    tick();
    chk_opc("bp_load", 3'd1, 3'd1);
    disp_valid_i = 8'h24;
    opc_ready_i  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      eu_valid_i   = (k < 2);
      eu_warp_id_i = 3'd6;
      eu_tag_i     = 3'd3;
      #1;
      chk($sformatf("bp%0d.ready", k), 64'(disp_ready_o), 64'h00);
      chk($sformatf("bp%0d.eu_vld", k), 64'(disp_eu_valid_o), (k < 2) ? 64'h40 : 64'h00);
      chk($sformatf("bp%0d.eu_tag", k), 64'(disp_eu_tag_o), 64'd3);
      tick();
      chk_opc($sformatf("bp%0d", k), 3'd1, 3'd1);
      chk($sformatf("bp%0d.pc", k), 64'(opc_pc_o), 64'h1010);
    end
    opc_ready_i = 1'b1;
    #1 chk("bp_rel.ready", 64'(disp_ready_o), 64'h04);
    tick();
    chk_opc("bp_rel", 3'd2, 3'd2);
    #1 chk("bp_next.ready", 64'(disp_ready_o), 64'h20);
    tick();
    chk_opc("bp_next", 3'd5, 3'd5);

    // Reset mid-stream with ptr 5 and an instruction held
    disp_valid_i = 8'h10;
    tick();
    chk_opc("mid_load", 3'd4, 3'd4);
    disp_valid_i = 8'h00;
    opc_ready_i  = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst.valid", 64'(opc_valid_o), 64'd0);
    chk("mid_rst.wid", 64'(opc_warp_id_o), 64'd0);
    chk("mid_rst.pc", 64'(opc_pc_o), 64'd0);
    rst_ni       = 1'b1;
    disp_valid_i = 8'h21;
    opc_ready_i  = 1'b1;
    #1 chk("post_rst.ready", 64'(disp_ready_o), 64'h01);
    tick();
    chk_opc("post_rst", 3'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
